// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255-style port A mode 1 slice.
// Holds the input/output handshake FSM state encodings and the port C
// bit positions that carry the mode 1 handshake lines.
package ppi_pkg;

    // Strobed-input side: latch empty or holding a byte for the CPU
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } in_state_t;

    // Strobed-output side: idle, byte pending for peripheral, acknowledged
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACKD = 2'd2
    } out_state_t;

    // Port C bit positions used by port A in mode 1
    localparam int PC3 = 3;  // INTR
    localparam int PC4 = 4;  // STB_n
    localparam int PC5 = 5;  // IBF
    localparam int PC6 = 6;  // ACK_n
    localparam int PC7 = 7;  // OBF_n

endpackage

// File: rtl/ppi_port_a_mode1_if.sv
// Bus bundle between the CPU/peripheral side and ppi_port_a_mode1.
// The slave modport is the port block's view; master is the environment.
// Optional build macro affecting the block behind this bundle: PPI_HS_SYNC_EN.
interface ppi_port_a_mode1_if #(
    parameter int DATA_W = 8
);
    logic              mode_out;
    logic              inte_set;
    logic              inte_clr;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] pa_in;
    logic [DATA_W-1:0] pa_out;
    logic              pa_oe;
    logic              stb_n;
    logic              ack_n;
    logic              ibf;
    logic              obf_n;
    logic              intr;
    logic              ovr;

    modport slave (
        input  mode_out, inte_set, inte_clr, cpu_wr, cpu_wdata, cpu_rd,
               pa_in, stb_n, ack_n,
        output cpu_rdata, pa_out, pa_oe, ibf, obf_n, intr, ovr
    );

    modport master (
        output mode_out, inte_set, inte_clr, cpu_wr, cpu_wdata, cpu_rd,
               pa_in, stb_n, ack_n,
        input  cpu_rdata, pa_out, pa_oe, ibf, obf_n, intr, ovr
    );
endinterface

// File: rtl/ppi_hs_sync.sv
// Handshake pin conditioner: optional 2-flop synchronizer followed by an
// edge-detect register. Fall/rise pulses are valid in the cycle where the
// registered copy is about to change, so the consuming FSM updates on the
// same clock edge that captures the new level.
// Build macro: PPI_HS_SYNC_EN (adds the synchronizer, 3 clk pin-to-response).
module ppi_hs_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_pin_n,
    output logic o_fall,
    output logic o_rise
);

`ifdef PPI_HS_SYNC_EN
    // Edges stay masked until the synchronizer holds a real pin sample
    localparam int ARM_LEN = 3;

    logic r_meta;
    logic r_sync;
    logic w_sampled;

    // Two-stage synchronizer, parked high (pin idle level) in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_pin_n;
            r_sync <= r_meta;
        end
    end

    assign w_sampled = r_sync;
`else
    // Only the very first cycle after reset is masked
    localparam int ARM_LEN = 1;

    logic w_sampled;

    assign w_sampled = i_pin_n;
`endif

    logic               r_q;
    logic [ARM_LEN-1:0] r_arm;
    logic               w_armed;

    // Edge-detect register plus arm shifter that blocks edges right after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= 1'b1;
            r_arm <= '0;
        end else begin
            r_q   <= w_sampled;
            r_arm <= (r_arm << 1) | ARM_LEN'(1);
        end
    end

    assign w_armed = r_arm[ARM_LEN-1];
    assign o_fall  = w_armed &  r_q & ~w_sampled;
    assign o_rise  = w_armed & ~r_q &  w_sampled;

endmodule

// File: rtl/ppi_port_a_mode1.sv
// 8255-style port A in mode 1: strobed input (STB_n/IBF) or strobed
// output (OBF_n/ACK_n), chosen statically by mode_out, with a shared
// interrupt line gated by the INTE flag and a sticky input overrun flag.
// Build macro: PPI_HS_SYNC_EN (synchronize STB_n/ACK_n before edge detect).
module ppi_port_a_mode1
    import ppi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit INTR_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    ppi_port_a_mode1_if.slave  bus
);

    logic              w_stb_fall;
    logic              w_stb_rise;
    logic              w_ack_fall;
    logic              w_ack_rise;

    logic              r_inte;
    in_state_t         r_in_state;
    out_state_t        r_out_state;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_pa_out;
    logic              r_ibf;
    logic              r_obf_n;
    logic              r_intr;
    logic              r_ovr;

    ppi_hs_sync u_stb_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pin_n (bus.stb_n),
        .o_fall  (w_stb_fall),
        .o_rise  (w_stb_rise)
    );

    ppi_hs_sync u_ack_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pin_n (bus.ack_n),
        .o_fall  (w_ack_fall),
        .o_rise  (w_ack_rise)
    );

    // Interrupt enable flag written by BSR pulses; clear beats set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inte <= INTR_RESET;
        end else if (bus.inte_clr) begin
            r_inte <= 1'b0;
        end else if (bus.inte_set) begin
            r_inte <= 1'b1;
        end
    end

    // Handshake FSMs; only the side selected by mode_out advances
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_state  <= EMPTY;
            r_out_state <= IDLE;
            r_rdata     <= '0;
            r_pa_out    <= '0;
            r_ibf       <= 1'b0;
            r_obf_n     <= 1'b1;
            r_intr      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (!bus.mode_out) begin
                case (r_in_state)
                    EMPTY: begin
                        if (w_stb_fall) begin
                            r_rdata    <= bus.pa_in;
                            r_ibf      <= 1'b1;
                            r_in_state <= FULL;
                        end
                    end
                    FULL: begin
                        if (w_stb_fall) begin
                            r_ovr <= 1'b1;
                        end
                        if (bus.cpu_rd) begin
                            r_ibf      <= 1'b0;
                            r_intr     <= 1'b0;
                            r_in_state <= EMPTY;
                        end else if (w_stb_rise) begin
                            r_intr <= r_inte;
                        end
                    end
                    default: begin
                        r_in_state <= EMPTY;
                    end
                endcase
            end else begin
                if (bus.cpu_wr) begin
                    r_pa_out    <= bus.cpu_wdata;
                    r_obf_n     <= 1'b0;
                    r_intr      <= 1'b0;
                    r_out_state <= PEND;
                end else begin
                    case (r_out_state)
                        IDLE: begin
                        end
                        PEND: begin
                            if (w_ack_fall) begin
                                r_obf_n     <= 1'b1;
                                r_out_state <= ACKD;
                            end
                        end
                        ACKD: begin
                            if (w_ack_rise) begin
                                r_intr      <= r_inte;
                                r_out_state <= IDLE;
                            end
                        end
                        default: begin
                            r_out_state <= IDLE;
                        end
                    endcase
                end
            end
            if (bus.inte_clr) begin
                r_intr <= 1'b0;
            end
        end
    end

    assign bus.pa_oe     = bus.mode_out;
    assign bus.cpu_rdata = r_rdata;
    assign bus.pa_out    = r_pa_out;
    assign bus.ibf       = r_ibf;
    assign bus.obf_n     = r_obf_n;
    assign bus.intr      = r_intr;
    assign bus.ovr       = r_ovr;

endmodule

// File: tb/tb_ppi_port_a_mode1.sv
// Directed bench for ppi_port_a_mode1: strobed input, overrun, reset
// mid-handshake, strobed output, write/ack collision and INTE handling.
// Expected values go into a scoreboard queue as stimulus is driven and are
// popped and compared when outputs are sampled on the falling clock edge.
// Honours PPI_HS_SYNC_EN for the handshake latency.
module tb_ppi_port_a_mode1;

`ifdef PPI_HS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int SEL_IBF   = 0;
    localparam int SEL_RDATA = 1;
    localparam int SEL_INTR  = 2;
    localparam int SEL_OVR   = 3;
    localparam int SEL_PAOUT = 4;
    localparam int SEL_OBFN  = 5;
    localparam int SEL_PAOE  = 6;
    localparam int SEL_LAT   = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks;
    int   errors;
    int   measLat;
    exp_t sb[$];

    ppi_port_a_mode1_if #(.DATA_W(8)) bus ();

    ppi_port_a_mode1 #(
        .DATA_W     (8),
        .INTR_RESET (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_IBF:   return {31'b0, bus.ibf};
            SEL_RDATA: return {24'b0, bus.cpu_rdata};
            SEL_INTR:  return {31'b0, bus.intr};
            SEL_OVR:   return {31'b0, bus.ovr};
            SEL_PAOUT: return {24'b0, bus.pa_out};
            SEL_OBFN:  return {31'b0, bus.obf_n};
            SEL_PAOE:  return {31'b0, bus.pa_oe};
            SEL_LAT:   return 32'(measLat);
            default:   return 'x;
        endcase
    endfunction

    task automatic pushExp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pushResetValues(input string pfx);
        pushExp({pfx, "_ibf"},   SEL_IBF,   0);
        pushExp({pfx, "_rdata"}, SEL_RDATA, 0);
        pushExp({pfx, "_intr"},  SEL_INTR,  0);
        pushExp({pfx, "_ovr"},   SEL_OVR,   0);
        pushExp({pfx, "_paout"}, SEL_PAOUT, 0);
        pushExp({pfx, "_obfn"},  SEL_OBFN,  1);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        measLat       = 0;
        reset         = 1'b1;
        bus.mode_out  = 1'b0;
        bus.inte_set  = 1'b0;
        bus.inte_clr  = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.cpu_rd    = 1'b0;
        bus.pa_in     = 8'h00;
        bus.stb_n     = 1'b1;
        bus.ack_n     = 1'b1;
        $display("[TB] start, handshake latency %0d clk", LAT);

        applyStimulus(3);
        pushResetValues("por");
        pushExp("por_paoe", SEL_PAOE, 0);
        checkOutput();
        reset = 1'b0;
        applyStimulus(2);

        bus.inte_set = 1'b1;
        applyStimulus(1);
        bus.inte_set = 1'b0;
        pushExp("in_intr_no_retro", SEL_INTR, 0);
        checkOutput();

        bus.pa_in = 8'hA5;
        bus.stb_n = 1'b0;
        measLat   = 0;
        while (bus.ibf !== 1'b1 && measLat < 10) begin
            @(posedge clk);
            #1;
            measLat++;
        end
        pushExp("stb_to_ibf_latency", SEL_LAT, LAT);
        checkOutput();
        @(negedge clk);
        applyStimulus(3);
        bus.pa_in = 8'h00;
        pushExp("in_ibf_full",     SEL_IBF,   1);
        pushExp("in_rdata_a5",     SEL_RDATA, 8'hA5);
        pushExp("in_intr_low_stb", SEL_INTR,  0);
        checkOutput();
        bus.stb_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("in_intr_after_rise", SEL_INTR,  1);
        pushExp("in_ibf_after_rise",  SEL_IBF,   1);
        pushExp("in_rdata_held",      SEL_RDATA, 8'hA5);
        checkOutput();
        bus.cpu_rd = 1'b1;
        applyStimulus(1);
        bus.cpu_rd = 1'b0;
        pushExp("in_rd_ibf",  SEL_IBF,  0);
        pushExp("in_rd_intr", SEL_INTR, 0);
        checkOutput();

        bus.pa_in = 8'h11;
        bus.stb_n = 1'b0;
        applyStimulus(LAT + 1);
        bus.stb_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("ovr_first_rdata", SEL_RDATA, 8'h11);
        pushExp("ovr_first_ovr",   SEL_OVR,   0);
        pushExp("ovr_first_intr",  SEL_INTR,  1);
        checkOutput();
        bus.pa_in = 8'h22;
        bus.stb_n = 1'b0;
        applyStimulus(LAT + 1);
        pushExp("ovr_second_rdata", SEL_RDATA, 8'h11);
        pushExp("ovr_second_ovr",   SEL_OVR,   1);
        pushExp("ovr_second_ibf",   SEL_IBF,   1);
        checkOutput();

        reset = 1'b1;
        applyStimulus(1);
        pushResetValues("rst_full");
        checkOutput();
        reset = 1'b0;
        applyStimulus(3);
        pushExp("rst_stb_low_ibf",   SEL_IBF,   0);
        pushExp("rst_stb_low_rdata", SEL_RDATA, 0);
        checkOutput();
        bus.stb_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("rst_empty_rise_intr", SEL_INTR, 0);
        pushExp("rst_empty_rise_ibf",  SEL_IBF,  0);
        checkOutput();

        bus.pa_in = 8'h33;
        bus.stb_n = 1'b0;
        applyStimulus(LAT + 1);
        bus.stb_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("rdcol_pre_ibf", SEL_IBF, 1);
        pushExp("rdcol_pre_ovr", SEL_OVR, 0);
        checkOutput();
        bus.pa_in = 8'h44;
        bus.stb_n = 1'b0;
        applyStimulus(LAT - 1);
        bus.cpu_rd = 1'b1;
        applyStimulus(1);
        bus.cpu_rd = 1'b0;
        pushExp("rdcol_ibf",   SEL_IBF,   0);
        pushExp("rdcol_ovr",   SEL_OVR,   1);
        pushExp("rdcol_rdata", SEL_RDATA, 8'h33);
        checkOutput();
        applyStimulus(2);
        pushExp("rdcol_dropped_ibf", SEL_IBF, 0);
        checkOutput();
        bus.stb_n = 1'b1;
        applyStimulus(LAT + 1);

        reset        = 1'b1;
        bus.mode_out = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        applyStimulus(2);
        pushExp("out_paoe", SEL_PAOE, 1);
        pushExp("out_obfn", SEL_OBFN, 1);
        pushExp("out_ovr",  SEL_OVR,  0);
        checkOutput();
        bus.inte_set = 1'b1;
        applyStimulus(1);
        bus.inte_set  = 1'b0;
        bus.cpu_wdata = 8'h3C;
        bus.cpu_wr    = 1'b1;
        applyStimulus(1);
        bus.cpu_wr = 1'b0;
        pushExp("out_wr_paout", SEL_PAOUT, 8'h3C);
        pushExp("out_wr_obfn",  SEL_OBFN,  0);
        pushExp("out_wr_intr",  SEL_INTR,  0);
        checkOutput();
        bus.stb_n = 1'b0;
        bus.ack_n = 1'b0;
        applyStimulus(LAT + 1);
        pushExp("out_ack_obfn",    SEL_OBFN,  1);
        pushExp("out_stb_ign_ibf", SEL_IBF,   0);
        pushExp("out_stb_ign_rd",  SEL_RDATA, 0);
        checkOutput();
        bus.stb_n = 1'b1;
        bus.ack_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("out_rise_intr", SEL_INTR, 1);
        pushExp("out_rise_obfn", SEL_OBFN, 1);
        checkOutput();
        bus.cpu_wdata = 8'h77;
        bus.cpu_wr    = 1'b1;
        applyStimulus(1);
        bus.cpu_wr = 1'b0;
        pushExp("out_wr2_intr",  SEL_INTR,  0);
        pushExp("out_wr2_obfn",  SEL_OBFN,  0);
        pushExp("out_wr2_paout", SEL_PAOUT, 8'h77);
        checkOutput();

        bus.cpu_wdata = 8'h55;
        bus.ack_n     = 1'b0;
        applyStimulus(LAT - 1);
        bus.cpu_wr = 1'b1;
        applyStimulus(1);
        bus.cpu_wr = 1'b0;
        pushExp("wrcol_obfn",  SEL_OBFN,  0);
        pushExp("wrcol_paout", SEL_PAOUT, 8'h55);
        checkOutput();
        applyStimulus(2);
        pushExp("wrcol_hold_obfn", SEL_OBFN, 0);
        checkOutput();
        bus.ack_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("wrcol_pend_rise_obfn", SEL_OBFN, 0);
        pushExp("wrcol_pend_rise_intr", SEL_INTR, 0);
        checkOutput();
        bus.ack_n = 1'b0;
        applyStimulus(LAT + 1);
        pushExp("wrcol_pend_fall_obfn", SEL_OBFN, 1);
        checkOutput();
        bus.ack_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("wrcol_done_intr", SEL_INTR, 1);
        checkOutput();

        bus.inte_clr = 1'b1;
        applyStimulus(1);
        bus.inte_clr = 1'b0;
        pushExp("inte_clr_intr", SEL_INTR, 0);
        checkOutput();
        bus.inte_set = 1'b1;
        applyStimulus(1);
        bus.inte_set = 1'b0;
        pushExp("inte_set_no_retro", SEL_INTR, 0);
        checkOutput();
        bus.ack_n = 1'b0;
        applyStimulus(LAT + 1);
        bus.ack_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("idle_ack_intr", SEL_INTR, 0);
        pushExp("idle_ack_obfn", SEL_OBFN, 1);
        checkOutput();

        bus.inte_set = 1'b1;
        bus.inte_clr = 1'b1;
        applyStimulus(1);
        bus.inte_set  = 1'b0;
        bus.inte_clr  = 1'b0;
        bus.cpu_wdata = 8'hAA;
        bus.cpu_wr    = 1'b1;
        applyStimulus(1);
        bus.cpu_wr = 1'b0;
        bus.ack_n  = 1'b0;
        applyStimulus(LAT + 1);
        bus.ack_n = 1'b1;
        applyStimulus(LAT + 1);
        pushExp("setclr_intr",  SEL_INTR,  0);
        pushExp("setclr_paout", SEL_PAOUT, 8'hAA);
        pushExp("setclr_obfn",  SEL_OBFN,  1);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppi_port_a_mode1.md
PPI_PORT_A_MODE1 -- requirements
Module: ppi_port_a_mode1

Interface
REQ-001 SHALL have parameter DATA_W, default 8, port data width.
REQ-002 SHALL have parameter INTR_RESET, default 0, reset value of inte_q.
REQ-003 SHALL have clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high.
REQ-005 SHALL have mode_out  input  1  1 = strobed output, 0 = strobed input; static between resets.
REQ-006 SHALL have inte_set, inte_clr  input  1 each  one-cycle pulses setting or clearing the interrupt enable (BSR writes).
REQ-007 SHALL have cpu_wr  input  1  one-cycle write strobe; cpu_wdata  input  DATA_W  write data.
REQ-008 SHALL have cpu_rd  input  1  one-cycle read strobe; cpu_rdata  output  DATA_W  input latch contents.
REQ-009 SHALL have pa_in  input  DATA_W, pa_out  output  DATA_W, pa_oe  output  1  port A pins.
REQ-010 SHALL have stb_n  input  1 (PC4) and ack_n  input  1 (PC6)  peripheral handshake, asynchronous.
REQ-011 SHALL have ibf  output  1 (PC5), obf_n  output  1 (PC7), intr  output  1 (PC3), ovr  output  1  sticky overrun.

Function
REQ-012 SHALL detect edges on stb_n/ack_n from a registered copy; "edge cycle" means the first clk edge where the registered sampled value differs from its previous value.
REQ-013 SHALL drive pa_oe = mode_out combinationally.
REQ-014 Input FSM states SHALL be EMPTY, FULL; active only when mode_out=0.
REQ-015 EMPTY + stb_n falling edge: latch pa_in into cpu_rdata, ibf=1, go FULL, same edge cycle.
REQ-016 FULL + stb_n rising edge: intr=inte_q, no state change.
REQ-017 FULL + cpu_rd: ibf=0, intr=0, go EMPTY next cycle.
REQ-018 FULL + stb_n falling edge: latch unchanged, ovr=1 (sticky until reset).
REQ-019 cpu_rd and stb_n falling edge in the same cycle while FULL: read wins (EMPTY), strobe is dropped and ovr=1.
REQ-020 Output FSM states SHALL be IDLE, PEND, ACKD; active only when mode_out=1.
REQ-021 Any state + cpu_wr: pa_out=cpu_wdata, obf_n=0, intr=0, go PEND next cycle.
REQ-022 PEND + ack_n falling edge: obf_n=1, go ACKD.
REQ-023 ACKD + ack_n rising edge: intr=inte_q, go IDLE.
REQ-024 cpu_wr in the same cycle as an ack_n edge: cpu_wr wins.
REQ-025 ack_n edges in IDLE, and stb_n in output mode, SHALL be ignored.
REQ-026 inte_clr SHALL force intr=0 next cycle; inte_set SHALL not assert intr retroactively; simultaneous set+clr: clr wins.
REQ-027 Data, ibf, obf_n, intr SHALL all be registered; no combinational path from any input to them.

Reset
REQ-028 On reset: states EMPTY/IDLE, cpu_rdata=0, pa_out=0, ibf=0, obf_n=1, intr=0, ovr=0, inte_q=INTR_RESET, synchronizer flops=1.
REQ-029 Reset mid-handshake SHALL abort the transfer; no edge SHALL be detected in the first cycle after reset.

Configuration
REQ-030 Macro PPI_HS_SYNC_EN: when defined, stb_n/ack_n SHALL pass through 2-flop synchronizers, giving edge-to-response latency of 3 clk.
REQ-031 Without PPI_HS_SYNC_EN, the pins SHALL feed the edge-detect register directly, giving latency of 1 clk.

Structure
REQ-032 Package ppi_pkg SHALL hold the input/output FSM state enums and the PC bit-position constants (PC3, PC4, PC5, PC6, PC7).
REQ-033 A sub-module ppi_hs_sync (synchronizer + edge detect, one instance per handshake pin) SHALL be used.

Verification
REQ-034 Input: inte_set; pa_in=8'hA5; stb_n low 4 clk then high -> ibf=1, cpu_rdata=8'hA5, intr=1 after rise; cpu_rd -> ibf=0, intr=0.
REQ-035 Overrun: FULL with 8'h11, second strobe with pa_in=8'h22 -> cpu_rdata stays 8'h11, ovr=1.
REQ-036 Output: inte_set; cpu_wr 8'h3C -> pa_out=8'h3C, obf_n=0; ack_n low -> obf_n=1; ack_n high -> intr=1; next cpu_wr -> intr=0.
REQ-037 Collision: cpu_wr 8'h55 in the ack_n falling-edge cycle -> obf_n stays 0, state PEND, pa_out=8'h55.
REQ-038 Reset while FULL with intr=1 -> all outputs at REQ-028 values next cycle; stb_n held low through reset -> no latch.
REQ-039 Latency: measure stb_n fall to ibf rise -> 3 clk with PPI_HS_SYNC_EN, 1 clk without.
